// File: rtl/dec_out_ctrl.sv
// dec_out_ctrl: replays one buffered codeword, applies err_val correction and streams it out with
// backpressure, a symbol index, SOP/EOP framing and one queued start.
module dec_out_ctrl #(
  parameter int SYM_BW     = 8,
  parameter int N_NUM      = 255,
  parameter int R_NUM      = 16,
  parameter int FIFO_LAT   = 1,
  parameter int OUT_PARITY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              err_loc_val_sync_i,
  input  logic              dec_fail_i,
  output logic              fifo_rd_o,
  input  logic [SYM_BW-1:0] fifo_out_i,
  output logic              err_rd_o,
  input  logic [SYM_BW-1:0] err_val_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [SYM_BW-1:0] symbol_out_o,
  output logic [7:0]        symbol_cnt_o,
  output logic              out_sop_o,
  output logic              out_eop_o,
  output logic              out_fail_o,
  output logic              busy_o,
  output logic              start_ovf_o
);
  localparam int K_NUM = N_NUM - R_NUM;
  localparam int DEPTH = FIFO_LAT + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [7:0] LAST = 8'((OUT_PARITY != 0) ? N_NUM - 1 : K_NUM - 1);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state_q, state_d;
  logic [7:0] rd_cnt_q, rd_cnt_d, ocnt_q;
  logic fail_q, fail_d, pend_q, pend_d, pend_fail_q, pend_fail_d, ovf_q, ovf_d;
  logic [FIFO_LAT-1:0] pipe_q;
  logic [SYM_BW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [3:0] occ_q, inflight;
  logic start, kept, rd, pop, arrive, drained, credit_ok, go;
  assign start = err_loc_val_sync_i;
  assign kept = (OUT_PARITY != 0) || (rd_cnt_q < 8'(K_NUM));
  assign pop = out_valid_o & out_ready_i;
  assign arrive = pipe_q[FIFO_LAT-1];
  assign drained = (inflight == 4'd0) && (occ_q == 4'd0);
  // a symbol leaving this cycle frees its slot in time for a new read
  assign credit_ok = (occ_q + inflight) < (4'(DEPTH) + {3'b0, pop});
  assign rd = (state_q == READ) && (credit_ok || !kept);
  always_comb begin
    inflight = '0;
    for (int i = 0; i < FIFO_LAT; i++) inflight = inflight + {3'b0, pipe_q[i]};
  end
  always_comb begin
    state_d = state_q;
    rd_cnt_d = rd_cnt_q;
    fail_d = fail_q;
    pend_d = pend_q;
    pend_fail_d = pend_fail_q;
    ovf_d = 1'b0;
    go = 1'b0;
    case (state_q)
      IDLE: go = start;
      READ: begin
        rd_cnt_d = rd ? rd_cnt_q + 8'd1 : rd_cnt_q;
        state_d = (rd && rd_cnt_q == 8'(N_NUM - 1)) ? DRAIN : READ;
      end
      DRAIN: begin
        go = drained & (pend_q | start);
        state_d = drained ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
    if (go) begin
      state_d = READ;
      rd_cnt_d = '0;
      fail_d = pend_q ? pend_fail_q : dec_fail_i;
      pend_d = 1'b0;
    end
    // a start not consumed directly goes to the slot, or is dropped if the slot is still full
    if (start && !(go && !pend_q)) begin
      ovf_d = pend_d;
      pend_fail_d = pend_d ? pend_fail_q : dec_fail_i;
      pend_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_cnt_q <= '0;
      fail_q <= 1'b0;
      pend_q <= 1'b0;
      pend_fail_q <= 1'b0;
      ovf_q <= 1'b0;
      pipe_q <= '0;
      occ_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      ocnt_q <= '0;
    end else begin
      state_q <= state_d;
      rd_cnt_q <= rd_cnt_d;
      fail_q <= fail_d;
      pend_q <= pend_d;
      pend_fail_q <= pend_fail_d;
      ovf_q <= ovf_d;
      pipe_q <= FIFO_LAT'({pipe_q, rd & kept});
      occ_q <= occ_q + {3'b0, arrive} - {3'b0, pop};
      if (arrive) wptr_q <= (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      if (pop) rptr_q <= (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      if (pop) ocnt_q <= out_eop_o ? 8'd0 : ocnt_q + 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (arrive) mem_q[wptr_q] <= fifo_out_i ^ (fail_q ? '0 : err_val_i);
  end
  assign fifo_rd_o = rd;
  assign err_rd_o = rd;
  assign out_valid_o = occ_q != 4'd0;
  assign symbol_out_o = out_valid_o ? mem_q[rptr_q] : '0;
  assign symbol_cnt_o = out_valid_o ? ocnt_q : 8'd0;
  assign out_sop_o = out_valid_o && ocnt_q == 8'd0;
  assign out_eop_o = out_valid_o && ocnt_q == LAST;
  assign busy_o = state_q != IDLE;
  assign out_fail_o = busy_o & fail_q;
  assign start_ovf_o = ovf_q;
endmodule
